// File: rtl/dna_pkg.sv
// Shared definitions for the deletion-correcting quaternary code blocks.
// Holds the digit type, the locator FSM state encoding and the default
// code parameters (word length, checksum modulus and the two residues).
package dna_pkg;

  typedef logic [1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_DEF  = 6;
  localparam int M_DEF  = 29;
  localparam int A0_DEF = 0;
  localparam int A1_DEF = 0;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: sum = (a + b) mod M.
// Both operands must already be below M, so one conditional subtraction
// of M is enough to bring the result back into range.
// Ports:
//   a, b : MW-bit operands, each < M
//   sum  : MW-bit result, < M
module mod_add #(
  parameter int M  = 29,
  parameter int MW = $clog2(M)
) (
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic [MW-1:0] sum
);

  logic [MW:0] raw_s;

  assign raw_s = {1'b0, a} + {1'b0, b};
  assign sum   = (raw_s >= (MW+1)'(M)) ? MW'(raw_s - (MW+1)'(M)) : raw_s[MW-1:0];

endmodule

// File: rtl/del_locate.sv
// Single-deletion locator for a quaternary code word.
// A received word of N digits is the N+1-digit codeword with one digit
// removed. The block recovers the deleted value from the digit-sum residue
// and then scans insertion positions k = 0..N until the weighted checksum
// matches, reporting the smallest matching k (or fail if none matches).
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake (ready only in IDLE)
//   word_in             : N digits, digit 0 in the MSB pair
//   out_valid/out_ready : output handshake (valid only in DONE)
//   word_out            : registered copy of the accepted word
//   missing_index       : insertion position k of the deleted digit
//   missing_digit       : value of the deleted digit
//   fail                : no insertion position satisfies the checksum
module del_locate
  import dna_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int A0 = A0_DEF,
  parameter int A1 = A1_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] word_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] word_out,
  output logic [6:0]     missing_index,
  output logic [1:0]     missing_digit,
  output logic           fail
);

  localparam int MW = $clog2(M);
  localparam int TW = $clog2(3*N+1);
  localparam logic [MW-1:0] A1_M = MW'(A1 % M);

  state_t          state_r, state_s;
  logic [6:0]      idx_r, idx_s;
  logic [2*N-1:0]  word_r, word_s;
  logic [TW-1:0]   t_r, t_s;          // full-width digit sum T
  logic [MW-1:0]   tm_r, tm_s;        // T mod M, seeds the mod-M tail
  logic [MW-1:0]   w_r, w_s;          // weighted sum W mod M
  logic [MW-1:0]   wt_r, wt_s;        // current weight (j+1) mod M
  digit_t          d_r, d_s;
  logic [MW-1:0]   add_r, add_s;      // running (k+1)*d mod M
  logic [TW-1:0]   tail_r, tail_s;    // sum of y_j for j >= k
  logic [MW-1:0]   tailm_r, tailm_s;  // same tail reduced mod M
  logic [6:0]      mi_r, mi_s;
  digit_t          md_r, md_s;
  logic            fail_r, fail_s;

  logic [2*N-1:0]  sh_s;
  digit_t          y_s;
  logic [MW-1:0]   wt2_s, wt3_s, term_s, w_acc_s, wt_inc_s, tm_acc_s;
  logic [MW-1:0]   c1_s, cand_s, add_inc_s, neg_y_s, tailm_dec_s;

  // Digit idx of the stored word: shift it up to the MSB pair.
  assign sh_s    = word_r << {idx_r, 1'b0};
  assign y_s     = sh_s[2*N-1 -: 2];
  assign neg_y_s = (y_s == 2'd0) ? {MW{1'b0}} : (MW'(M) - MW'(y_s));

  // Weighted term (j+1)*y selected from 1x/2x/3x multiples of the weight.
  mod_add #(.M(M), .MW(MW)) u_wt2   (.a(wt_r),    .b(wt_r),        .sum(wt2_s));
  mod_add #(.M(M), .MW(MW)) u_wt3   (.a(wt2_s),   .b(wt_r),        .sum(wt3_s));
  mod_add #(.M(M), .MW(MW)) u_w     (.a(w_r),     .b(term_s),      .sum(w_acc_s));
  mod_add #(.M(M), .MW(MW)) u_wt    (.a(wt_r),    .b(MW'(1)),      .sum(wt_inc_s));
  mod_add #(.M(M), .MW(MW)) u_tm    (.a(tm_r),    .b(MW'(y_s)),    .sum(tm_acc_s));
  mod_add #(.M(M), .MW(MW)) u_c1    (.a(w_r),     .b(add_r),       .sum(c1_s));
  mod_add #(.M(M), .MW(MW)) u_cand  (.a(c1_s),    .b(tailm_r),     .sum(cand_s));
  mod_add #(.M(M), .MW(MW)) u_add   (.a(add_r),   .b(MW'(d_r)),    .sum(add_inc_s));
  mod_add #(.M(M), .MW(MW)) u_tailm (.a(tailm_r), .b(neg_y_s),     .sum(tailm_dec_s));

  // Select the weighted contribution of the current digit.
  always_comb begin
    term_s = {MW{1'b0}};
    case (y_s)
      2'd0:    term_s = {MW{1'b0}};
      2'd1:    term_s = wt_r;
      2'd2:    term_s = wt2_s;
      2'd3:    term_s = wt3_s;
      default: term_s = {MW{1'b0}};
    endcase
  end

  // Next-state and datapath update for the IDLE/ACC/SEARCH/DONE sequence.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    word_s  = word_r;
    t_s     = t_r;
    tm_s    = tm_r;
    w_s     = w_r;
    wt_s    = wt_r;
    d_s     = d_r;
    add_s   = add_r;
    tail_s  = tail_r;
    tailm_s = tailm_r;
    mi_s    = mi_r;
    md_s    = md_r;
    fail_s  = fail_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = ACC;
          word_s  = word_in;
          idx_s   = 7'd0;
          t_s     = {TW{1'b0}};
          tm_s    = {MW{1'b0}};
          w_s     = {MW{1'b0}};
          wt_s    = MW'(1);
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        t_s  = t_r + TW'(y_s);
        tm_s = tm_acc_s;
        w_s  = w_acc_s;
        wt_s = wt_inc_s;
        if (idx_r == 7'(N-1)) begin
          // Digit-sum residue alone fixes the deleted value.
          state_s = SEARCH;
          idx_s   = 7'd0;
          d_s     = 2'(A0) - t_s[1:0];
          add_s   = MW'(d_s);
          tail_s  = t_s;
          tailm_s = tm_s;
        end else begin
          idx_s = idx_r + 7'd1;
        end
      end
      SEARCH: begin
        if (cand_s == A1_M) begin
          state_s = DONE;
          mi_s    = idx_r;
          md_s    = d_r;
          fail_s  = 1'b0;
        end else if (idx_r < 7'(N)) begin
          // Moving the insertion point past y_k removes it from the tail.
          tail_s  = tail_r - TW'(y_s);
          tailm_s = tailm_dec_s;
          add_s   = add_inc_s;
          idx_s   = idx_r + 7'd1;
        end else begin
          state_s = DONE;
          mi_s    = 7'd0;
          md_s    = d_r;
          fail_s  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= 7'd0;
      word_r  <= {(2*N){1'b0}};
      t_r     <= {TW{1'b0}};
      tm_r    <= {MW{1'b0}};
      w_r     <= {MW{1'b0}};
      wt_r    <= {MW{1'b0}};
      d_r     <= 2'd0;
      add_r   <= {MW{1'b0}};
      tail_r  <= {TW{1'b0}};
      tailm_r <= {MW{1'b0}};
      mi_r    <= 7'd0;
      md_r    <= 2'd0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      word_r  <= word_s;
      t_r     <= t_s;
      tm_r    <= tm_s;
      w_r     <= w_s;
      wt_r    <= wt_s;
      d_r     <= d_s;
      add_r   <= add_s;
      tail_r  <= tail_s;
      tailm_r <= tailm_s;
      mi_r    <= mi_s;
      md_r    <= md_s;
      fail_r  <= fail_s;
    end
  end

  assign in_ready      = (state_r == IDLE);
  assign out_valid     = (state_r == DONE);
  assign word_out      = word_r;
  assign missing_index = mi_r;
  assign missing_digit = md_r;
  assign fail          = fail_r;

endmodule

// File: tb/tb_del_locate.sv
// Scoreboard bench for del_locate: the driver pushes the expected result of
// every accepted word, the monitor compares whenever out_valid is presented.
module tb_del_locate;

  localparam int N  = 6;
  localparam int M  = 29;
  localparam int A0 = 0;
  localparam int A1 = 0;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] word_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] word_out;
  logic [6:0]     missing_index;
  logic [1:0]     missing_digit;
  logic           fail;

  typedef struct {
    logic [2*N-1:0] w;
    int mi;
    int md;
    int f;
    int lat;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   tot_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  int   sent_cnt = 0;
  int   res_cnt  = 0;
  int   last_hs  = -1;
  int   last_acc = -1;
  int   rdy_mode = 0;
  bit   ov_prev  = 1'b0;

  del_locate #(.N(N), .M(M), .A0(A0), .A1(A1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .word_in(word_in), .out_valid(out_valid), .out_ready(out_ready),
    .word_out(word_out), .missing_index(missing_index),
    .missing_digit(missing_digit), .fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  // Reference: try every insertion position with the digit forced by the
  // digit-sum rule, rebuild the N+1-digit word and test the weighted sum.
  function automatic void ref_model(input logic [2*N-1:0] w, output int k_o,
                                    output int d_o, output int f_o);
    int y[N];
    int c[N+1];
    int t, ws;
    t = 0;
    for (int j = 0; j < N; j++) begin
      y[j] = int'(w[2*N-1-2*j -: 2]);
      t += y[j];
    end
    d_o = ((A0 - t) % 4 + 4) % 4;
    k_o = 0;
    f_o = 1;
    for (int k = 0; k <= N; k++) begin
      if (f_o == 1) begin
        ws = 0;
        for (int j = 0; j <= N; j++) begin
          c[j] = (j < k) ? y[j] : ((j == k) ? d_o : y[j-1]);
          ws += (j + 1) * c[j];
        end
        if (ws % M == A1) begin
          k_o = k;
          f_o = 0;
        end
      end
    end
  endfunction

  // Random codeword with one random digit deleted.
  function automatic logic [2*N-1:0] gen_valid();
    int c[N+1];
    int s, ws, del, p;
    logic [2*N-1:0] w;
    bit found;
    found = 1'b0;
    for (int tries = 0; tries < 10000 && !found; tries++) begin
      s = 0;
      ws = 0;
      for (int j = 0; j < N; j++) begin
        c[j] = int'($urandom_range(0, 3));
        s += c[j];
      end
      c[N] = ((A0 - s) % 4 + 4) % 4;
      for (int j = 0; j <= N; j++) ws += (j + 1) * c[j];
      if (ws % M == A1) found = 1'b1;
    end
    del = int'($urandom_range(0, N));
    w = '0;
    p = 0;
    for (int j = 0; j <= N; j++) begin
      if (j != del) begin
        w[2*N-1-2*p -: 2] = 2'(c[j]);
        p++;
      end
    end
    return w;
  endfunction

  task automatic send_item(input logic [2*N-1:0] w, input bit push, input bit use_spec,
                           input int mi, input int md, input int f, input int lat);
    exp_t e;
    int n, k, d, ff;
    @(negedge clk);
    in_valid = 1'b1;
    word_in  = w;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      e.w   = w;
      e.acc = cyc + 1;
      if (use_spec) begin
        e.mi = mi; e.md = md; e.f = f; e.lat = lat;
      end else begin
        ref_model(w, k, d, ff);
        e.mi = k; e.md = d; e.f = ff;
        e.lat = N + ((ff == 1) ? N : k) + 1;
      end
      last_acc = e.acc;
      if (push) begin
        exp_q.push_back(e);
        sent_cnt++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      word_in  = 2*N'($urandom);
    end
  endtask

  task automatic send(input logic [2*N-1:0] w);
    send_item(w, 1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_word_out"}, int'(word_out), 0);
    chk({tag, "_missing_index"}, int'(missing_index), 0);
    chk({tag, "_missing_digit"}, int'(missing_digit), 0);
    chk({tag, "_fail"}, int'(fail), 0);
  endtask

  // Monitor: compare presented results against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_out: actual word_out %0d, required no output", word_out);
      end else begin
        e_mon = exp_q[0];
        if (!ov_prev) chk("latency", cyc - e_mon.acc, e_mon.lat);
        chk("word_out", int'(word_out), int'(e_mon.w));
        chk("missing_index", int'(missing_index), e_mon.mi);
        chk("missing_digit", int'(missing_digit), e_mon.md);
        chk("fail", int'(fail), e_mon.f);
        chk("in_ready_in_done", int'(in_ready), 0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          res_cnt++;
          last_hs = cyc + 1;
        end
      end
    end
    ov_prev = out_valid;
  end

  // out_ready driver: always ready, random, or held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] w2;
    int n;
    rst      = 1'b0;
    in_valid = 1'b0;
    word_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    send_item(12'h555, 1'b1, 1'b1, 0, 2, 0, 7);
    send_item(12'h955, 1'b1, 1'b1, 1, 1, 0, 8);
    send_item(12'h001, 1'b1, 1'b1, 0, 3, 1, 13);
    drain();

    // Stall in DONE with a pending new word.
    rdy_mode = 2;
    send(gen_valid());
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(out_valid), 1);
    w2 = gen_valid();
    in_valid = 1'b1;
    word_in  = w2;
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    send(w2);
    chk("reaccept_cycle", last_acc, last_hs + 1);
    drain();

    // Reset in the third ACC cycle abandons the word.
    send_item(gen_valid(), 1'b0, 1'b0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset("mid_acc_reset");
    send(gen_valid());
    drain();

    for (int i = 0; i < 48; i++) begin
      if (i == 24) rdy_mode = 1;
      if ($urandom_range(0, 1) == 1) send(gen_valid());
      else send(2*N'($urandom));
    end
    drain();
    rdy_mode = 0;
    chk("result_count", res_cnt, sent_cnt);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
